// File: rtl/lfsr_decrypt_engine.sv
// Blind LFSR stream-cipher decryptor, master on the single-port DataRAM.
// Build option LFSR_DEC_RECOVER_EN also stores the recovered tap byte and seed at addresses 42/43.
module lfsr_decrypt_engine #(
   parameter int SRC_BASE = 64,
   parameter int SRC_LEN  = 64,
   parameter int MSG_LEN  = 41,
   parameter int PRE_MIN  = 9
) (
   input  logic       CLK,
   input  logic       reset_n,
   input  logic       start,
   input  logic [7:0] mem_rd_data,
   output logic [7:0] mem_addr,
   output logic       mem_wr_en,
   output logic [7:0] mem_wr_data,
   output logic       done,
   output logic       error,
   output logic [2:0] ptrn_idx
);
   // state  | meaning
   // IDLE   | waiting for start after reset
   // SEED   | read first source byte, seed = byte ^ 20h
   // SEARCH | try tap pattern k against the space preamble
   // SKIP   | step over remaining leading spaces
   // WR_W   | write decrypted byte j
   // WR_R   | read the next source byte
   // REC_T  | write recovered tap byte
   // REC_S  | write recovered seed
   // DONE   | result valid, waiting for start
   typedef enum logic [3:0] {IDLE, SEED, SEARCH, SKIP, WR_W, WR_R, REC_T, REC_S, DONE} state_t;

   localparam logic [7:0] SPACE    = 8'h20;
   localparam logic [7:0] BASE     = 8'(SRC_BASE);
   localparam logic [6:0] LEN      = 7'(SRC_LEN);
   localparam logic [6:0] PRE_LAST = 7'(PRE_MIN - 1);
   localparam logic [5:0] MSG_LAST = 6'(MSG_LEN - 1);

   function automatic logic [7:0] tap_of(input logic [2:0] k);
      case (k)
         3'd0:    tap_of = 8'hE1;
         3'd1:    tap_of = 8'hD4;
         3'd2:    tap_of = 8'hC6;
         3'd3:    tap_of = 8'hB8;
         3'd4:    tap_of = 8'hB4;
         3'd5:    tap_of = 8'hB2;
         3'd6:    tap_of = 8'hFA;
         default: tap_of = 8'hF3;
      endcase
   endfunction

   function automatic logic [7:0] lfsr_step(input logic [7:0] s, input logic [7:0] t);
      return {s[6:0], ^(s & t)};
   endfunction

   state_t     state_q, state_d;
   logic [2:0] k_q, k_d, ptrn_q, ptrn_d;
   logic [6:0] idx_q, idx_d, idx_inc;
   logic [5:0] j_q, j_d;
   logic [7:0] s0_q, s0_d, lfsr_q, lfsr_d, addr_q, addr_d, wr_data_q, wr_data_d;
   logic       wr_en_q, wr_en_d, done_q, done_d, error_q, error_d;
   logic [7:0] rd_plain, dec, lfsr_next;

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      ptrn_d    = ptrn_q;
      idx_d     = idx_q;
      j_d       = j_q;
      s0_d      = s0_q;
      lfsr_d    = lfsr_q;
      addr_d    = addr_q;
      wr_en_d   = 1'b0;
      wr_data_d = wr_data_q;
      done_d    = done_q;
      error_d   = error_q;
      rd_plain  = mem_rd_data ^ SPACE;
      dec       = mem_rd_data ^ lfsr_q;
      lfsr_next = lfsr_step(lfsr_q, tap_of(k_q));
      idx_inc   = idx_q + 7'd1;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = SEED;
               done_d  = 1'b0;
               error_d = 1'b0;
               addr_d  = BASE;
            end
         end
         SEED: begin
            s0_d    = rd_plain;
            k_d     = 3'd0;
            lfsr_d  = lfsr_step(rd_plain, tap_of(3'd0));
            idx_d   = 7'd1;
            addr_d  = BASE + 8'd1;
            state_d = SEARCH;
         end
         SEARCH: begin
            if (rd_plain == lfsr_q) begin
               lfsr_d = lfsr_next;
               idx_d  = idx_inc;
               addr_d = BASE + {1'b0, idx_inc};
               if (idx_q == PRE_LAST) begin
                  ptrn_d  = k_q;
                  state_d = SKIP;
               end
            end else if (k_q == 3'd7) begin
               error_d = 1'b1;
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               // next candidate restarts from the seed at index 1
               k_d    = k_q + 3'd1;
               lfsr_d = lfsr_step(s0_q, tap_of(k_q + 3'd1));
               idx_d  = 7'd1;
               addr_d = BASE + 8'd1;
            end
         end
         SKIP: begin
            if (dec != SPACE || idx_q == LEN - 7'd1) begin
               idx_d     = (dec != SPACE) ? idx_q : LEN;
               wr_data_d = dec;
               j_d       = 6'd0;
               addr_d    = 8'd0;
               wr_en_d   = 1'b1;
               state_d   = WR_W;
            end else begin
               lfsr_d = lfsr_next;
               idx_d  = idx_inc;
               addr_d = BASE + {1'b0, idx_inc};
            end
         end
         WR_W: begin
            if (j_q == MSG_LAST) begin
`ifdef LFSR_DEC_RECOVER_EN
               addr_d    = 8'd42;
               wr_en_d   = 1'b1;
               wr_data_d = tap_of(k_q);
               state_d   = REC_T;
`else
               done_d  = 1'b1;
               state_d = DONE;
`endif
            end else begin
               idx_d   = idx_inc;
               lfsr_d  = lfsr_next;
               addr_d  = (idx_inc < LEN) ? BASE + {1'b0, idx_inc} : BASE;
               state_d = WR_R;
            end
         end
         WR_R: begin
            j_d       = j_q + 6'd1;
            addr_d    = {2'b00, j_q + 6'd1};
            wr_en_d   = 1'b1;
            wr_data_d = (idx_q < LEN) ? dec : SPACE;
            state_d   = WR_W;
         end
`ifdef LFSR_DEC_RECOVER_EN
         REC_T: begin
            addr_d    = 8'd43;
            wr_en_d   = 1'b1;
            wr_data_d = s0_q;
            state_d   = REC_S;
         end
         REC_S: begin
            done_d  = 1'b1;
            state_d = DONE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         k_q       <= 3'd0;
         ptrn_q    <= 3'd0;
         idx_q     <= 7'd0;
         j_q       <= 6'd0;
         s0_q      <= 8'd0;
         lfsr_q    <= 8'd0;
         addr_q    <= 8'd0;
         wr_en_q   <= 1'b0;
         wr_data_q <= 8'd0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         ptrn_q    <= ptrn_d;
         idx_q     <= idx_d;
         j_q       <= j_d;
         s0_q      <= s0_d;
         lfsr_q    <= lfsr_d;
         addr_q    <= addr_d;
         wr_en_q   <= wr_en_d;
         wr_data_q <= wr_data_d;
         done_q    <= done_d;
         error_q   <= error_d;
      end
   end

   assign mem_addr    = addr_q;
   assign mem_wr_en   = wr_en_q;
   assign mem_wr_data = wr_data_q;
   assign done        = done_q;
   assign error       = error_q;
   assign ptrn_idx    = ptrn_q;
endmodule

// File: tb/tb_lfsr_decrypt_engine.sv
// Scoreboard bench for lfsr_decrypt_engine: a whole-block reference decryptor predicts
// every memory write and the done cycle; a monitor process checks what the DUT presents.
module tb_lfsr_decrypt_engine;
   localparam int PRE_MIN = 9;
`ifdef LFSR_DEC_RECOVER_EN
   localparam int REC_EXTRA = 2;
`else
   localparam int REC_EXTRA = 0;
`endif
   localparam logic [7:0] TAPS [8] = '{8'hE1, 8'hD4, 8'hC6, 8'hB8, 8'hB4, 8'hB2, 8'hFA, 8'hF3};

   typedef struct {logic [7:0] addr; logic [7:0] data;} wr_t;
   typedef struct {logic err; logic [2:0] ptrn; int cyc;} res_t;

   logic       CLK = 1'b0, reset_n = 1'b0, start = 1'b0, load_req = 1'b0;
   logic [7:0] mem_rd_data, mem_addr, mem_wr_data;
   logic       mem_wr_en, done, error;
   logic [2:0] ptrn_idx;
   logic [7:0] mem [256];
   logic [7:0] img [256];
   logic [7:0] plain [64];
   logic [7:0] exp_msg [41];
   logic       exp_err, done_seen = 1'b0;
   logic [2:0] exp_ptrn;
   logic [7:0] exp_tap, exp_seed;
   int         exp_lat, cyc = 0, wr_cnt = 0, checks = 0, errors = 0;
   wr_t        wq[$];
   res_t       rq[$];

   lfsr_decrypt_engine dut (
      .CLK(CLK), .reset_n(reset_n), .start(start), .mem_rd_data(mem_rd_data),
      .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
      .done(done), .error(error), .ptrn_idx(ptrn_idx));

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;
   assign mem_rd_data = mem[mem_addr];

   always @(posedge CLK) begin
      if (load_req) begin
         for (int a = 0; a < 256; a++) mem[a] <= img[a];
      end else if (mem_wr_en) begin
         mem[mem_addr] <= mem_wr_data;
      end
   end

   // monitor: checks every write strobe and every rising done against the queues
   always @(negedge CLK) begin
      wr_t we;
      res_t re;
      if (mem_wr_en) begin
         wr_cnt++;
         checks++;
         if (wq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: addr=%h data=%h, none expected", mem_addr, mem_wr_data);
         end else begin
            we = wq.pop_front();
            if (mem_addr !== we.addr || mem_wr_data !== we.data) begin
               errors++;
               $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                        mem_addr, mem_wr_data, we.addr, we.data);
            end
         end
      end
      if (done && !done_seen) begin
         checks++;
         if (rq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: done rose with no job outstanding");
         end else begin
            re = rq.pop_front();
            if (error !== re.err || (!re.err && ptrn_idx !== re.ptrn) || cyc != re.cyc || wq.size() != 0) begin
               errors++;
               $display("FAIL result: got error=%0b ptrn=%0d cycle=%0d pending_writes=%0d, expected error=%0b ptrn=%0d cycle=%0d pending_writes=0",
                        error, ptrn_idx, cyc, wq.size(), re.err, re.ptrn, re.cyc);
            end
         end
      end
      done_seen = done;
   end

   function automatic logic [7:0] nxt(input logic [7:0] s, input logic [7:0] t);
      return {s[6:0], 1'($countones(s & t) % 2)};
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   task automatic set_plain(input int pre, input string msg);
      for (int i = 0; i < 64; i++) plain[i] = 8'h20;
      for (int j = 0; j < msg.len(); j++) if (pre + j < 64) plain[pre + j] = msg[j];
   endtask

   task automatic build_img(input logic [7:0] tap, input logic [7:0] seed);
      logic [7:0] s;
      s = seed;
      for (int a = 0; a < 256; a++) img[a] = 8'hEE;
      img[42] = 8'hAA;
      img[43] = 8'h55;
      for (int i = 0; i < 64; i++) begin
         img[64 + i] = plain[i] ^ s;
         s = nxt(s, tap);
      end
   endtask

   task automatic commit();
      @(negedge CLK) load_req = 1'b1;
      @(negedge CLK) load_req = 1'b0;
   endtask

   // reference: try each pattern on the preamble, decrypt the whole block, strip leading spaces
   task automatic model();
      logic [7:0] s, s0;
      logic [7:0] d [64];
      int ns, miss, f;
      s0 = img[64] ^ 8'h20;
      ns = 0;
      exp_err = 1'b1;
      exp_ptrn = 3'd0;
      for (int k = 0; k < 8 && exp_err; k++) begin
         s = s0;
         miss = 0;
         for (int i = 1; i < PRE_MIN && miss == 0; i++) begin
            s = nxt(s, TAPS[k]);
            if (s != (img[64 + i] ^ 8'h20)) miss = i;
         end
         if (miss != 0) ns += miss;
         else begin
            ns += PRE_MIN - 1;
            exp_err = 1'b0;
            exp_ptrn = 3'(k);
         end
      end
      exp_lat = 1 + ns;
      if (!exp_err) begin
         exp_tap = TAPS[exp_ptrn];
         exp_seed = s0;
         s = s0;
         for (int i = 0; i < 64; i++) begin
            d[i] = img[64 + i] ^ s;
            s = nxt(s, exp_tap);
         end
         f = 64;
         for (int i = 63; i >= 0; i--) if (d[i] != 8'h20) f = i;
         for (int j = 0; j < 41; j++) exp_msg[j] = (f + j < 64) ? d[f + j] : 8'h20;
         exp_lat += ((f < 64) ? f - PRE_MIN + 1 : 64 - PRE_MIN) + 2 * 41 - 1 + REC_EXTRA;
      end
   endtask

   task automatic issue(input bit mid_start);
      res_t r;
      model();
      if (!exp_err) begin
         for (int j = 0; j < 41; j++) wq.push_back('{8'(j), exp_msg[j]});
`ifdef LFSR_DEC_RECOVER_EN
         wq.push_back('{8'd42, exp_tap});
         wq.push_back('{8'd43, exp_seed});
`endif
      end
      @(negedge CLK);
      start = 1'b1;
      r.err = exp_err;
      r.ptrn = exp_ptrn;
      r.cyc = cyc + 1 + exp_lat;
      rq.push_back(r);
      @(negedge CLK) start = 1'b0;
      if (mid_start) begin
         repeat (2) @(negedge CLK);
         start = 1'b1;
         @(negedge CLK) start = 1'b0;
      end
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!done && n < 400) begin
         @(negedge CLK);
         n++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: done still %0b after %0d cycles, expected 1", done, n);
         wq.delete();
         rq.delete();
         reset_n = 1'b0;
         repeat (2) @(negedge CLK);
         reset_n = 1'b1;
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic check_tail();
`ifdef LFSR_DEC_RECOVER_EN
      chk("mem42", mem[42], exp_err ? 8'hAA : exp_tap);
      chk("mem43", mem[43], exp_err ? 8'h55 : exp_seed);
`else
      chk("mem42", mem[42], 8'hAA);
      chk("mem43", mem[43], 8'h55);
`endif
   endtask

   task automatic random_block();
      int pre, m;
      pre = $urandom_range(20, PRE_MIN);
      m = $urandom_range(64 - pre, 1);
      set_plain(0, "");
      plain[pre] = 8'($urandom_range(126, 33));
      for (int j = 1; j < m; j++) plain[pre + j] = 8'($urandom_range(126, 32));
      build_img(TAPS[$urandom_range(7, 0)], 8'($urandom));
      if ($urandom_range(3, 0) == 0)
         for (int i = 0; i < 64; i++) img[64 + i] = 8'($urandom);
      commit();
   endtask

   initial begin
      string watson, ajok;
      int w0;
      watson = "Mr. Watson, come here. I want to see you.";
      ajok = "Ajok";
      repeat (2) @(negedge CLK);
      chk("rst_addr", mem_addr, 8'h00);
      chk("rst_wr_en", 8'(mem_wr_en), 8'h00);
      chk("rst_wr_data", mem_wr_data, 8'h00);
      chk("rst_done", 8'(done), 8'h00);
      chk("rst_error", 8'(error), 8'h00);
      chk("rst_ptrn", 8'(ptrn_idx), 8'h00);
      reset_n = 1'b1;

      set_plain(9, watson);
      build_img(8'hD4, 8'h47);
      commit();
      issue(0);
      wait_done();
      chk("watson_ptrn", 8'(ptrn_idx), 8'd1);
      chk("watson_error", 8'(error), 8'd0);
      for (int j = 0; j < 41; j++) chk("watson_msg", mem[j], watson[j]);
      check_tail();

      set_plain(10, "   Ajok");
      build_img(8'hFA, 8'h08);
      commit();
      issue(0);
      wait_done();
      chk("ajok_ptrn", 8'(ptrn_idx), 8'd6);
      for (int j = 0; j < 41; j++) chk("ajok_msg", mem[j], (j < 4) ? ajok[j] : 8'h20);

      build_img(8'hE1, 8'h00);
      for (int i = 0; i < 64; i++) img[64 + i] = 8'h00;
      commit();
      w0 = wr_cnt;
      issue(0);
      wait_done();
      chk("zero_error", 8'(error), 8'd1);
      chk("zero_done", 8'(done), 8'd1);
      chk("zero_writes", 8'(wr_cnt - w0), 8'd0);
      check_tail();

      set_plain(64, "");
      build_img(8'hF3, 8'h01);
      commit();
      issue(0);
      wait_done();
      chk("spaces_error", 8'(error), 8'd0);
      for (int j = 0; j < 41; j++) chk("spaces_msg", mem[j], 8'h20);

      set_plain(9, "Hello");
      build_img(8'hB2, 8'h5C);
      commit();
      issue(0);
      wait_done();
      chk("rec_ptrn", 8'(ptrn_idx), 8'd5);
`ifdef LFSR_DEC_RECOVER_EN
      chk("rec_tap", mem[42], 8'hB2);
      chk("rec_seed", mem[43], 8'h5C);
`else
      chk("rec_keep42", mem[42], 8'hAA);
      chk("rec_keep43", mem[43], 8'h55);
`endif

      set_plain(9, watson);
      build_img(8'hD4, 8'h47);
      commit();
      issue(1);
      wait_done();
      chk("midstart_ptrn", 8'(ptrn_idx), 8'd1);

      set_plain(9, watson);
      build_img(8'hD4, 8'h47);
      commit();
      issue(0);
      begin
         int n;
         n = 0;
         while (!(mem_wr_en && mem_addr == 8'd10) && n < 400) begin
            @(negedge CLK);
            n++;
         end
         checks++;
         if (!(mem_wr_en && mem_addr == 8'd10)) begin
            errors++;
            $display("FAIL reach_j10: write to address 10 not seen within %0d cycles", n);
         end
      end
      @(posedge CLK);
      #2 reset_n = 1'b0;
      #1;
      chk("abort_addr", mem_addr, 8'h00);
      chk("abort_wr_en", 8'(mem_wr_en), 8'h00);
      chk("abort_wr_data", mem_wr_data, 8'h00);
      chk("abort_done", 8'(done), 8'h00);
      chk("abort_error", 8'(error), 8'h00);
      chk("abort_ptrn", 8'(ptrn_idx), 8'h00);
      wq.delete();
      rq.delete();
      w0 = wr_cnt;
      repeat (3) @(negedge CLK);
      reset_n = 1'b1;
      repeat (6) @(negedge CLK);
      chk("abort_no_writes", 8'(wr_cnt - w0), 8'd0);
      chk("abort_mem10", mem[10], exp_msg[10]);
      chk("abort_mem11", mem[11], 8'hEE);

      for (int t = 0; t < 14; t++) begin
         random_block();
         issue(t == 3);
         wait_done();
         chk("rand_done", 8'(done), 8'd1);
         check_tail();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
